// File: rtl/toggle_updown_counter_pkg.sv
// Shared definitions for the toggle-cell up/down counter.
// Direction encoding and the next-count rule used by the counter.
package toggle_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Next count of a mod-modulo counter for one enabled step.
  function automatic int unsigned next_count(
    input int unsigned q,
    input logic        up,
    input int unsigned modulo
  );
    if (up == DIR_UP) begin
      return (q >= modulo - 32'd1) ? 32'd0 : q + 32'd1;
    end
    return (q == 32'd0) ? modulo - 32'd1 : q - 32'd1;
  endfunction

endpackage

// File: rtl/toggle_updown_counter_cell.sv
// Single-bit negedge toggle register with sync reset.
// Holds q and its complement as two registered bits.
module toggle_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);

  // Toggle on t, clear to q=0/qbar=1 on reset.
  always_ff @(negedge clk) begin
    if (rst) begin
      q    <= 1'b0;
      qbar <= 1'b1;
    end else if (t) begin
      q    <= ~q;
      qbar <= ~qbar;
    end
  end

endmodule

// File: rtl/toggle_updown_counter.sv
// Mod-N up/down counter built from toggle cells.
// Generates per-bit toggles, terminal count and wrap pulse.
module toggle_updown_counter
  import toggle_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("MODULO must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   LAST_X = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] LAST_Q = WIDTH'(MODULO - 1);

  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   din_x;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             at_top;
  logic             at_zero;

  assign q_x     = {1'b0, q};
  assign din_x   = {1'b0, din};
  assign at_top  = (q_x == LAST_X);
  assign at_zero = (q == '0);

  assign tc = en & (((up == DIR_UP) & at_top) |
                    ((up == DIR_DOWN) & at_zero));

  // Target count; load goes through the toggle path too.
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = (din_x < MOD_X) ? din : LAST_Q;
    end else if (en) begin
      nxt = WIDTH'(next_count(32'(q), up, MODULO));
    end
  end

  assign t = q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    toggle_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .t    (t[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  // One-period pulse on an enabled wrap; load and reset suppress it.
  always_ff @(negedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc & ~load;
    end
  end

endmodule

// File: tb/tb_toggle_updown_counter.sv
// Scoreboard bench for toggle_updown_counter.
// Covers MODULO 10, 16 and 2 with directed vectors.
module tb_toggle_updown_counter;

  typedef struct {
    int         sel;
    logic [3:0] q;
    logic       wrap;
    logic       chk_tc;
    logic       tc;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic up = 1'b1;
  logic load = 1'b0;
  logic [3:0] din = '0;

  logic [3:0] q0, qb0, q1, qb1, q2, qb2;
  logic tc0, tc1, tc2, w0, w1, w2;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic tcs[3];

  always #5 clk = ~clk;

  toggle_updown_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q0), .qbar(qb0), .tc(tc0), .wrap(w0)
  );

  toggle_updown_counter #(.WIDTH(4), .MODULO(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q1), .qbar(qb1), .tc(tc1), .wrap(w1)
  );

  toggle_updown_counter #(.WIDTH(4), .MODULO(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q2), .qbar(qb2), .tc(tc2), .wrap(w2)
  );

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  task automatic drive(
    input logic r, input logic e, input logic u, input logic l,
    input logic [3:0] d, input int s,
    input logic [3:0] eq, input logic ew,
    input logic ct, input logic et, input string nm
  );
    exp_t x;
    @(posedge clk);
    rst = r; en = e; up = u; load = l; din = d;
    x.sel = s; x.q = eq; x.wrap = ew;
    x.chk_tc = ct; x.tc = et; x.name = nm;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t       x;
    logic [3:0] aq, aqb;
    logic       aw, at;
    forever begin
      @(posedge clk);
      #1;
      tcs[0] = tc0; tcs[1] = tc1; tcs[2] = tc2;
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        case (x.sel)
          1:       begin aq = q1; aqb = qb1; aw = w1; end
          2:       begin aq = q2; aqb = qb2; aw = w2; end
          default: begin aq = q0; aqb = qb0; aw = w0; end
        endcase
        at = tcs[x.sel];
        chk({x.name, ".q"}, aq, x.q);
        chk({x.name, ".qbar"}, aqb, ~x.q);
        chk({x.name, ".wrap"}, {3'b0, aw}, {3'b0, x.wrap});
        if (x.chk_tc) begin
          chk({x.name, ".tc"}, {3'b0, at}, {3'b0, x.tc});
        end
      end
    end
  end

  initial begin : stim
    drive(1,0,1,0,0, 0, 0,0, 0,0, "reset");
    for (int k = 0; k < 12; k++) begin
      drive(0,1,1,0,0, 0, 4'((k+1) % 10), k == 9, 1, k == 9, "up");
    end
    drive(1,1,0,0,0, 0, 0,0, 1,0, "rst_mid");
    drive(0,1,0,0,0, 0, 9,1, 1,1, "down_wrap");
    drive(0,1,0,0,0, 0, 8,0, 1,0, "down8");
    drive(0,1,0,0,0, 0, 7,0, 1,0, "down7");
    drive(0,0,1,1,13, 0, 9,0, 1,0, "load_clamp");
    drive(0,1,1,1,3, 0, 3,0, 1,1, "load_over_en");
    drive(0,0,1,1,10, 0, 9,0, 1,0, "load_eq_mod");
    drive(0,1,1,1,5, 0, 5,0, 1,1, "load_at_tc");
    drive(0,0,1,1,6, 0, 6,0, 1,0, "load6");
    for (int k = 0; k < 5; k++) begin
      drive(0,0,1,0,0, 0, 6,0, 1,0, "hold");
    end
    drive(0,0,1,1,9, 0, 9,0, 1,0, "load9");
    drive(1,1,1,0,0, 0, 0,0, 1,1, "rst_at_tc");
    drive(0,1,1,0,0, 0, 1,0, 1,0, "resume");
    drive(0,1,0,0,0, 0, 0,0, 1,0, "dir_change");
    drive(0,1,0,0,0, 0, 9,1, 1,1, "down_wrap0");
    drive(0,1,1,0,0, 0, 0,1, 1,1, "wrap_again");
    drive(0,0,1,0,0, 0, 0,0, 1,0, "idle");
    drive(1,0,1,0,0, 1, 0,0, 0,0, "rst16");
    drive(0,0,1,1,15, 1, 15,0, 1,0, "load15");
    drive(0,1,1,0,0, 1, 0,1, 1,1, "wrap16");
    drive(0,1,1,0,0, 1, 1,0, 1,0, "after16");
    drive(1,0,1,0,0, 2, 0,0, 0,0, "rst2");
    drive(0,1,1,0,0, 2, 1,0, 1,0, "m2_a");
    drive(0,1,1,0,0, 2, 0,1, 1,1, "m2_b");
    drive(0,1,1,0,0, 2, 1,0, 1,0, "m2_c");
    drive(0,1,1,0,0, 2, 0,1, 1,1, "m2_d");
    @(posedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
